note_seq_ctrl: RTL



---
 rtl/note_seq_ctrl_if.sv | 38 +++
 rtl/note_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/note_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// note_seq_ctrl_if
//
// Purpose:
//   Bus between the note sequencer and the 8 x 4-bit note register file.
//   The sequencer is the only agent that drives the write enable, address
//   and write data lines; the register file only returns read data.
//
// Signals:
//   rf_rw     1  register-file RW (1 = write enable, 0 = read)
//   rf_addr   3  register-file address
//   rf_wdata  4  register-file write data
//   rf_rdata  4  register-file read data, combinational from rf_addr
//
// Modports:
//   master  sequencer side (drives rf_rw/rf_addr/rf_wdata, samples rf_rdata)
//   slave   register-file side
// -----------------------------------------------------------------------------
interface note_seq_ctrl_if;
    logic       rf_rw;
    logic [2:0] rf_addr;
    logic [3:0] rf_wdata;
    logic [3:0] rf_rdata;

    modport master (
        output rf_rw,
        output rf_addr,
        output rf_wdata,
        input  rf_rdata
    );

    modport slave (
        input  rf_rw,
        input  rf_addr,
        input  rf_wdata,
        output rf_rdata
    );
endinterface

// File: rtl/note_seq_ctrl.sv
// -----------------------------------------------------------------------------
// note_seq_ctrl
//
// Purpose:
//   Record/playback sequencer for the electronic piano's 8-entry x 4-bit note
//   register file.
//     - REC  : each key press is written to the next free address (0..7).
//     - PLAY : entries 0..count-1 are read back in order; each note is shown
//              on note_out for TEMPO_DIV+1 clock cycles (one fetch cycle plus
//              TEMPO_DIV wait cycles).
//   This block is the only driver of the register file's RW/address/data-in
//   lines and never touches the stored contents outside REC write cycles.
//
// Configuration:
//   NOTE_SEQ_LOOP_EN  defined   : playback wraps to entry 0 after the last
//                                 note and repeats until stop.
//                     undefined : playback ends after the last note and the
//                                 block returns to IDLE.
//
// Parameters:
//   TEMPO_DIV  clk cycles spent waiting per note (minimum 2)
//   DEPTH      number of register-file entries (fixed at 8, 3-bit address)
//
// Ports:
//   clk         in   1  system clock, all state on rising edge
//   rst         in   1  asynchronous, active-high reset
//   rec_start   in   1  pulse, begin recording (from IDLE only)
//   play_start  in   1  pulse, begin playback (from IDLE, needs count > 0)
//   stop        in   1  pulse, abort record/playback
//   key_valid   in   1  pulse, key_code valid
//   key_code    in   4  note code of pressed key
//   rf          if      register-file bus (master side)
//   note_out    out  4  current playback note
//   note_valid  out  1  high while note_out holds a played note
//   count       out  4  number of recorded notes, 0..8
//   busy        out  1  high when not IDLE
//   full        out  1  count == 8
// -----------------------------------------------------------------------------
module note_seq_ctrl #(
    parameter int TEMPO_DIV = 50000,
    parameter int DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rec_start,
    input  logic                   play_start,
    input  logic                   stop,
    input  logic                   key_valid,
    input  logic [3:0]             key_code,
    note_seq_ctrl_if.master        rf,
    output logic [3:0]             note_out,
    output logic                   note_valid,
    output logic [3:0]             count,
    output logic                   busy,
    output logic                   full
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_REC        = 2'd1;
    localparam logic [1:0] S_PLAY_FETCH = 2'd2;
    localparam logic [1:0] S_PLAY_WAIT  = 2'd3;

    localparam int            TW         = $clog2(TEMPO_DIV);
    localparam logic [TW-1:0] TEMPO_LAST = TW'(TEMPO_DIV - 1);
    localparam logic [3:0]    COUNT_MAX  = 4'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]    state;
    logic [2:0]    ptr;
    logic [TW-1:0] tempo_cnt;
    logic          more_notes;

    // Another recorded note follows the current one (ptr+1 < count),
    // evaluated at 4 bits so that ptr = 7 does not wrap.
    assign more_notes = ({1'b0, ptr} + 4'd1) < count;

    // Status flags are pure decodes of registered state.
    assign busy = (state != S_IDLE);
    assign full = (count == COUNT_MAX);

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so that all of them sample
    // the pre-edge values of each other; a blocking = would let later
    // statements see already-updated state and break the cycle timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            tempo_cnt   <= '0;
            count       <= '0;
            note_out    <= '0;
            note_valid  <= 1'b0;
            rf.rf_rw    <= 1'b0;
            rf.rf_addr  <= '0;
            rf.rf_wdata <= '0;
        end else begin
            // Write enable is a one-cycle strobe; only an accepted key in REC
            // raises it again below.
            rf.rf_rw <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rec_start) begin
                        // rec_start has priority over a simultaneous play_start.
                        state <= S_REC;
                        count <= '0;
                    end else if (play_start && (count != 4'd0)) begin
                        state      <= S_PLAY_FETCH;
                        ptr        <= '0;
                        rf.rf_addr <= '0;
                    end
                end

                S_REC: begin
                    if (stop) begin
                        // stop beats a same-cycle key_valid: nothing is written.
                        state <= S_IDLE;
                    end else if (key_valid && !full) begin
                        rf.rf_rw    <= 1'b1;
                        rf.rf_addr  <= count[2:0];
                        rf.rf_wdata <= key_code;
                        count       <= count + 4'd1;
                    end
                end

                S_PLAY_FETCH: begin
                    if (stop) begin
                        state      <= S_IDLE;
                        note_valid <= 1'b0;
                        note_out   <= '0;
                    end else begin
                        // rf_addr has held ptr for this whole cycle, so the
                        // combinational read data is settled here.
                        note_out   <= rf.rf_rdata;
                        note_valid <= 1'b1;
                        tempo_cnt  <= '0;
                        state      <= S_PLAY_WAIT;
                    end
                end

                S_PLAY_WAIT: begin
                    if (stop) begin
                        state      <= S_IDLE;
                        note_valid <= 1'b0;
                        note_out   <= '0;
                    end else if (tempo_cnt == TEMPO_LAST) begin
                        if (more_notes) begin
                            ptr        <= ptr + 3'd1;
                            rf.rf_addr <= ptr + 3'd1;
                            state      <= S_PLAY_FETCH;
                        end else begin
`ifdef NOTE_SEQ_LOOP_EN
                            // Wrap to the first note and keep playing.
                            ptr        <= '0;
                            rf.rf_addr <= '0;
                            state      <= S_PLAY_FETCH;
`else
                            // Sequence finished: clear the note and go idle.
                            state      <= S_IDLE;
                            note_valid <= 1'b0;
                            note_out   <= '0;
`endif
                        end
                    end else begin
                        tempo_cnt <= tempo_cnt + TW'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
